// File: rtl/msx_bus_pkg.sv
// Shared types for the Z80-timed cartridge bus master.
package msx_bus_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} bus_state_t;

  typedef struct packed {
    logic        io;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/msx_tstate_timer.sv
// Divides CLK into Z80 T-states while the bus cycle runs; restarts at zero whenever idle.
module msx_tstate_timer #(
  parameter int TSTATE_CLKS = 4
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic run,
  output logic half_tick,
  output logic end_tick
);

  localparam int CW = $clog2(TSTATE_CLKS);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)
      cnt <= '0;
    else if (!run || end_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // half_tick marks the clock whose closing edge starts the second half of the T-state
  assign half_tick = run && (cnt == CW'(TSTATE_CLKS / 2 - 1));
  assign end_tick  = run && (cnt == CW'(TSTATE_CLKS - 1));

endmodule

// File: rtl/msx_bus_master.sv
// Host-side slot initiator: turns single-beat requests into Z80 memory/I/O cycles,
// inserting wait states from WAIT_n and aborting with ERR after WAIT_TIMEOUT waits.
module msx_bus_master
  import msx_bus_pkg::*;
#(
  parameter int TSTATE_CLKS  = 4,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ,
  input  logic        REQ_IO,
  input  logic        REQ_WR,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        ACK,
  output logic [7:0]  RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic [15:0] ADDR,
  output logic [7:0]  DOUT,
  input  logic [7:0]  DIN,
  output logic        SLTSL_n,
  output logic        MERQ_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  input  logic        WAIT_n
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

  bus_state_t     state, state_nx;
  bus_req_t       req_q;
  logic [WCW-1:0] wait_cnt;
  logic           err_q;
  logic           ack_pend;
  logic           half_tick, end_tick;
  logic           accept, wait_hit, timeout;

  msx_tstate_timer #(.TSTATE_CLKS(TSTATE_CLKS)) u_timer (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .run       (state != IDLE),
    .half_tick (half_tick),
    .end_tick  (end_tick)
  );

  // ack_pend blocks the clock that raises ACK, ACK itself blocks the next one
  assign accept   = (state == IDLE) && REQ && !ACK && !ack_pend;
  assign wait_hit = !WAIT_n;
  assign timeout  = (wait_cnt == WCW'(WAIT_TIMEOUT));
  assign ADDR     = req_q.addr;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = T1;
      T1:   if (end_tick) state_nx = T2;
      // I/O always takes one forced wait; memory only on a sampled WAIT_n low
      T2:   if (end_tick) state_nx = (req_q.io || wait_hit) ? TW : T3;
      TW:   if (end_tick) state_nx = (wait_hit && !timeout) ? TW : T3;
      T3:   if (end_tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      req_q    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      ack_pend <= 1'b0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      RDATA    <= 8'h00;
      DOUT     <= 8'h00;
      SLTSL_n  <= 1'b1;
      MERQ_n   <= 1'b1;
      IORQ_n   <= 1'b1;
      RD_n     <= 1'b1;
      WR_n     <= 1'b1;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      if (ack_pend) begin
        ACK      <= 1'b1;
        ERR      <= err_q;
        BUSY     <= 1'b0;
        ack_pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            req_q    <= '{io: REQ_IO, wr: REQ_WR, addr: REQ_ADDR, wdata: REQ_WDATA};
            BUSY     <= 1'b1;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        T1: begin
          if (half_tick) begin
            if (req_q.io) begin
              IORQ_n <= 1'b0;
            end else begin
              MERQ_n  <= 1'b0;
              SLTSL_n <= 1'b0;
            end
            if (!req_q.wr) RD_n <= 1'b0;
          end
          if (end_tick && req_q.wr) begin
            DOUT <= req_q.wdata;
            WR_n <= 1'b0;
          end
        end
        T2: begin
          if (end_tick)
            wait_cnt <= (!req_q.io && wait_hit) ? WCW'(1) : '0;
        end
        TW: begin
          if (end_tick && wait_hit) begin
            if (timeout)
              err_q <= 1'b1;
            else
              wait_cnt <= wait_cnt + 1'b1;
          end
        end
        T3: begin
          if (end_tick) begin
            if (!req_q.wr) RDATA <= DIN;
            SLTSL_n  <= 1'b1;
            MERQ_n   <= 1'b1;
            IORQ_n   <= 1'b1;
            RD_n     <= 1'b1;
            WR_n     <= 1'b1;
            ack_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
